// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable datapath between two
// requesters, with per-beat requester tags that route results back after LATENCY.
module pipe_share_arbiter #(
  parameter int LATENCY    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  flush_in,
  input  logic [DATA_WIDTH-1:0] a_data_in,
  input  logic                  a_valid_in,
  output logic                  a_ready_out,
  input  logic [DATA_WIDTH-1:0] b_data_in,
  input  logic                  b_valid_in,
  output logic                  b_ready_out,
  output logic [DATA_WIDTH-1:0] pipe_data_out,
  input  logic [DATA_WIDTH-1:0] pipe_data_in,
  output logic [DATA_WIDTH-1:0] a_result_out,
  output logic                  a_result_valid_out,
  output logic [DATA_WIDTH-1:0] b_result_out,
  output logic                  b_result_valid_out,
  output logic                  busy_out
);

  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  grant_any_s;
  logic                  last_b_r;
  logic [LATENCY-1:0]    tag_valid_r;
  logic [LATENCY-1:0]    tag_id_r;
  logic [LATENCY-1:0]    tag_valid_nxt_s;
  logic [LATENCY-1:0]    tag_id_nxt_s;
  logic                  tail_a_s;
  logic                  tail_b_s;
  logic [DATA_WIDTH-1:0] a_result_r;
  logic [DATA_WIDTH-1:0] b_result_r;
  logic                  a_result_valid_r;
  logic                  b_result_valid_r;
  logic                  busy_r;

  // Arbitration: the requester that did not win last time takes a contended cycle.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (flush_in) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else begin
      case ({a_valid_in, b_valid_in})
        2'b10: grant_a_s = 1'b1;
        2'b01: grant_b_s = 1'b1;
        2'b11: begin
          if (last_b_r) begin
            grant_a_s = 1'b1;
          end else begin
            grant_b_s = 1'b1;
          end
        end
        default: begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
      endcase
    end
  end

  assign grant_any_s = grant_a_s | grant_b_s;
  assign a_ready_out = grant_a_s;
  assign b_ready_out = grant_b_s;

  // Datapath input mux; zero when idle so the pipe never sees stale payloads.
  always_comb begin
    pipe_data_out = {DATA_WIDTH{1'b0}};
    if (grant_a_s) begin
      pipe_data_out = a_data_in;
    end else if (grant_b_s) begin
      pipe_data_out = b_data_in;
    end else begin
      pipe_data_out = {DATA_WIDTH{1'b0}};
    end
  end

  // Next state of the tag shift chain; a flush empties every stage.
  always_comb begin
    tag_valid_nxt_s = {LATENCY{1'b0}};
    tag_id_nxt_s    = {LATENCY{1'b0}};
    if (flush_in) begin
      tag_valid_nxt_s = {LATENCY{1'b0}};
      tag_id_nxt_s    = {LATENCY{1'b0}};
    end else begin
      tag_valid_nxt_s[0] = grant_any_s;
      tag_id_nxt_s[0]    = grant_b_s;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_nxt_s[i] = tag_valid_r[i-1];
        tag_id_nxt_s[i]    = tag_id_r[i-1];
      end
    end
  end

  // Tail decode: which requester owns the result now on pipe_data_in.
  always_comb begin
    tail_a_s = 1'b0;
    tail_b_s = 1'b0;
    if (flush_in) begin
      tail_a_s = 1'b0;
      tail_b_s = 1'b0;
    end else if (tag_valid_r[LATENCY-1]) begin
      tail_a_s = ~tag_id_r[LATENCY-1];
      tail_b_s = tag_id_r[LATENCY-1];
    end else begin
      tail_a_s = 1'b0;
      tail_b_s = 1'b0;
    end
  end

  // Tag chain and occupancy flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_valid_r <= {LATENCY{1'b0}};
      tag_id_r    <= {LATENCY{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      tag_valid_r <= tag_valid_nxt_s;
      tag_id_r    <= tag_id_nxt_s;
      busy_r      <= |tag_valid_nxt_s;
    end
  end

  // Last-winner pointer; resets to B so A wins the first contention.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_b_r <= 1'b1;
    end else if (grant_any_s) begin
      last_b_r <= grant_b_s;
    end
  end

  // Result routing; data holds between strobes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_result_r       <= {DATA_WIDTH{1'b0}};
      b_result_r       <= {DATA_WIDTH{1'b0}};
      a_result_valid_r <= 1'b0;
      b_result_valid_r <= 1'b0;
    end else begin
      a_result_valid_r <= tail_a_s;
      b_result_valid_r <= tail_b_s;
      if (tail_a_s) begin
        a_result_r <= pipe_data_in;
      end
      if (tail_b_s) begin
        b_result_r <= pipe_data_in;
      end
    end
  end

  assign a_result_out       = a_result_r;
  assign b_result_out       = b_result_r;
  assign a_result_valid_out = a_result_valid_r;
  assign b_result_valid_out = b_result_valid_r;
  assign busy_out           = busy_r;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Drives three arbiter instances (LATENCY 2, 1, 5) with shared stimulus and checks
// each against a queue-based reference model of issue, delivery, flush and reset.
module tb_pipe_share_arbiter;
  localparam int DW = 8;

  logic          clk_in     = 1'b0;
  logic          rst_n_in   = 1'b0;
  logic          flush_in   = 1'b0;
  logic          a_valid_in = 1'b0;
  logic          b_valid_in = 1'b0;
  logic [DW-1:0] a_data_in  = 8'h00;
  logic [DW-1:0] b_data_in  = 8'h00;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int lat, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d got=%0h want=%0h t=%0t", tag, lat, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } ent_t;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);

    logic          a_ready_out, b_ready_out;
    logic          a_result_valid_out, b_result_valid_out, busy_out;
    logic [DW-1:0] pipe_data_out, pipe_data_in, a_result_out, b_result_out;
    logic [DW-1:0] dp [LAT];

    pipe_share_arbiter #(.LATENCY(LAT), .DATA_WIDTH(DW)) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .flush_in           (flush_in),
      .a_data_in          (a_data_in),
      .a_valid_in         (a_valid_in),
      .a_ready_out        (a_ready_out),
      .b_data_in          (b_data_in),
      .b_valid_in         (b_valid_in),
      .b_ready_out        (b_ready_out),
      .pipe_data_out      (pipe_data_out),
      .pipe_data_in       (pipe_data_in),
      .a_result_out       (a_result_out),
      .a_result_valid_out (a_result_valid_out),
      .b_result_out       (b_result_out),
      .b_result_valid_out (b_result_valid_out),
      .busy_out           (busy_out)
    );

    // Stand-in datapath: fixed delay chain with a visible transform, no enable.
    always @(posedge clk_in) begin
      dp[0] <= pipe_data_out ^ 8'h5A;
      for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
    end
    assign pipe_data_in = dp[LAT-1];

    ent_t          q[$];
    ent_t          e;
    logic          last_b = 1'b1;
    int            edge_n = 0;
    logic          ga, gb;
    logic          ea_v = 1'b0, eb_v = 1'b0, e_busy = 1'b0;
    logic [DW-1:0] ea_d = 8'h00, eb_d = 8'h00;

    // Reference model: update on the rising edge, compare on the falling edge.
    always @(posedge clk_in or negedge clk_in) begin
      if (clk_in) begin
        if (rst_n_in) begin
          edge_n++;
          ga = !flush_in && a_valid_in && (!b_valid_in || last_b);
          gb = !flush_in && b_valid_in && (!a_valid_in || !last_b);
          ea_v = 1'b0;
          eb_v = 1'b0;
          if (flush_in) begin
            q.delete();
          end else if (q.size() > 0 && q[0].due == edge_n) begin
            e = q.pop_front();
            if (e.id) begin eb_v = 1'b1; eb_d = e.data; end
            else begin ea_v = 1'b1; ea_d = e.data; end
          end
          if (ga) begin
            q.push_back('{due: edge_n + LAT, id: 1'b0, data: a_data_in ^ 8'h5A});
            last_b = 1'b0;
          end else if (gb) begin
            q.push_back('{due: edge_n + LAT, id: 1'b1, data: b_data_in ^ 8'h5A});
            last_b = 1'b1;
          end
          e_busy = (q.size() != 0);
        end
      end else begin
        if (!rst_n_in) begin
          q.delete();
          last_b = 1'b1;
          ea_v = 1'b0; eb_v = 1'b0; e_busy = 1'b0;
          ea_d = 8'h00; eb_d = 8'h00;
        end
        ga = !flush_in && a_valid_in && (!b_valid_in || last_b);
        gb = !flush_in && b_valid_in && (!a_valid_in || !last_b);
        chk("a_ready", LAT, 32'(a_ready_out), 32'(ga));
        chk("b_ready", LAT, 32'(b_ready_out), 32'(gb));
        chk("pipe_data", LAT, 32'(pipe_data_out), ga ? 32'(a_data_in) : (gb ? 32'(b_data_in) : 32'd0));
        chk("a_res_valid", LAT, 32'(a_result_valid_out), 32'(ea_v));
        chk("b_res_valid", LAT, 32'(b_result_valid_out), 32'(eb_v));
        chk("a_res_data", LAT, 32'(a_result_out), 32'(ea_d));
        chk("b_res_data", LAT, 32'(b_result_out), 32'(eb_d));
        chk("busy", LAT, 32'(busy_out), 32'(e_busy));
      end
    end
  end

  task automatic drive(input logic av, input logic [DW-1:0] ad, input logic bv,
                       input logic [DW-1:0] bd, input logic fl);
    @(posedge clk_in);
    #1;
    a_valid_in = av;
    a_data_in  = ad;
    b_valid_in = bv;
    b_data_in  = bd;
    flush_in   = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk_in);
    #1;
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    flush_in   = 1'b0;
    #2;
    rst_n_in = 1'b0;
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b1;
    idle(2);

    drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    idle(8);

    for (int n = 0; n < 6; n++) drive(1'b1, 8'(8'h10 + n), 1'b1, 8'(8'h20 + n), 1'b0);
    idle(8);

    drive(1'b0, 8'h00, 1'b1, 8'hB0, 1'b0);
    idle(3);
    drive(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0);
    idle(8);

    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h66, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(2);
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    idle(8);

    drive(1'b1, 8'h81, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h82, 1'b0);
    pulse_reset();
    idle(6);
    drive(1'b1, 8'hC1, 1'b1, 8'hC2, 1'b0);
    idle(8);

    for (int n = 1; n <= 8; n++) drive(1'b1, 8'(n), 1'b0, 8'h00, 1'b0);
    idle(8);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 60,
              8'($urandom), $urandom_range(0, 31) == 0);
      end
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
